// File: rtl/k_and_s_datapath.sv
// K&S processor datapath: PC, IR, 4-entry register file, ALU, flags and RAM address/data muxing.
// Build macro K_AND_S_R0_ZERO_EN hardwires register r0 to zero.
package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP, I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO,
        I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_HALT
    } decoded_instruction_type;
endpackage

module k_and_s_datapath
    import k_and_s_pkg::*;
#(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 5,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    write_reg_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic [1:0]              operation,
    input  logic                    flags_reg_enable,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       ram_data_out,
    input  logic [DATA_W-1:0]       ram_data_in
);

    localparam int unsigned MSB = DATA_W - 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] regs_d [4];
    logic              zero_q, zero_d, neg_q, neg_d, uov_q, uov_d, sov_q, sov_d;

    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic [DATA_W:0]   alu_wide;
    logic [1:0]        wr_dest;
    logic [DATA_W-1:0] wr_data;

    always_comb begin
        decoded_instruction = I_NOP;
        case (ir_q[15:8])
            8'h01:   decoded_instruction = I_BRANCH;
            8'h02:   decoded_instruction = I_BZERO;
            8'h03:   decoded_instruction = I_BNEG;
            8'h04:   decoded_instruction = I_BOV;
            8'h05:   decoded_instruction = I_BNOV;
            8'h0A:   decoded_instruction = I_BNNEG;
            8'h0B:   decoded_instruction = I_BNZERO;
            8'h81:   decoded_instruction = I_LOAD;
            8'h82:   decoded_instruction = I_STORE;
            8'h91:   decoded_instruction = I_MOVE;
            8'hA1:   decoded_instruction = I_ADD;
            8'hA2:   decoded_instruction = I_SUB;
            8'hA3:   decoded_instruction = I_AND;
            8'hA4:   decoded_instruction = I_OR;
            8'hFF:   decoded_instruction = I_HALT;
            default: decoded_instruction = I_NOP;
        endcase
    end

    // MOVE feeds A into both ALU inputs so the OR operation copies A.
    always_comb begin
        alu_a    = regs_q[ir_q[3:2]];
        alu_b    = (decoded_instruction == I_MOVE) ? alu_a : regs_q[ir_q[5:4]];
        alu_wide = '0;
        uov_d    = 1'b0;
        sov_d    = 1'b0;
        case (operation)
            2'b01: begin
                alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
                uov_d    = alu_wide[DATA_W];
                sov_d    = (alu_a[MSB] == alu_b[MSB]) && (alu_wide[MSB] != alu_a[MSB]);
            end
            2'b10: begin
                // Bit DATA_W of the widened difference is the borrow (A < B unsigned).
                alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
                uov_d    = alu_wide[DATA_W];
                sov_d    = (alu_a[MSB] != alu_b[MSB]) && (alu_wide[MSB] != alu_a[MSB]);
            end
            2'b11:   alu_wide = {1'b0, alu_a & alu_b};
            default: alu_wide = {1'b0, alu_a | alu_b};
        endcase
        alu_result = alu_wide[DATA_W-1:0];
        zero_d     = (alu_result == '0);
        neg_d      = alu_result[MSB];
    end

    always_comb begin
        regs_d  = regs_q;
        wr_dest = c_sel ? ir_q[1:0] : ir_q[6:5];
        wr_data = c_sel ? alu_result : ram_data_in;
        if (write_reg_enable) begin
            regs_d[wr_dest] = wr_data;
        end
`ifdef K_AND_S_R0_ZERO_EN
        regs_d[0] = '0;
`endif
        pc_d = pc_q;
        if (pc_enable) begin
            pc_d = branch ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
        end
        ir_d = ir_enable ? ram_data_in : ir_q;
    end

    // NOTE: the register file is small and must read 0 after reset, so it is reset like any other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= PC_RESET;
            ir_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            uov_q  <= 1'b0;
            sov_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values (old-value reads).
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            regs_q <= regs_d;
            if (flags_reg_enable) begin
                zero_q <= zero_d;
                neg_q  <= neg_d;
                uov_q  <= uov_d;
                sov_q  <= sov_d;
            end
        end
    end

    assign zero_op           = zero_q;
    assign neg_op            = neg_q;
    assign unsigned_overflow = uov_q;
    assign signed_overflow   = sov_q;
    assign ram_addr          = addr_sel ? ir_q[ADDR_W-1:0] : pc_q;
    assign ram_data_out      = regs_q[ir_q[6:5]];

endmodule

// File: tb/tb_k_and_s_datapath.sv
// Self-checking bench for k_and_s_datapath: a reference model queues expected values,
// which are popped and compared as the DUT outputs are sampled.
module tb_k_and_s_datapath;
    import k_and_s_pkg::*;

    localparam int DW = 16;
    localparam int AW = 5;

    logic                    clk, rst_n, branch, pc_enable, ir_enable, write_reg_enable;
    logic                    addr_sel, c_sel, flags_reg_enable;
    logic [1:0]              operation;
    decoded_instruction_type decoded_instruction;
    logic                    zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic [AW-1:0]           ram_addr;
    logic [DW-1:0]           ram_data_out, ram_data_in;

    k_and_s_datapath dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .branch             (branch),
        .pc_enable          (pc_enable),
        .ir_enable          (ir_enable),
        .write_reg_enable   (write_reg_enable),
        .addr_sel           (addr_sel),
        .c_sel              (c_sel),
        .operation          (operation),
        .flags_reg_enable   (flags_reg_enable),
        .decoded_instruction(decoded_instruction),
        .zero_op            (zero_op),
        .neg_op             (neg_op),
        .unsigned_overflow  (unsigned_overflow),
        .signed_overflow    (signed_overflow),
        .ram_addr           (ram_addr),
        .ram_data_out       (ram_data_out),
        .ram_data_in        (ram_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    logic [DW-1:0] m_reg [4];
    logic [AW-1:0] m_pc;
    logic          m_z, m_n, m_u, m_s;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        sb_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, got, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        branch = 0; pc_enable = 0; ir_enable = 0; write_reg_enable = 0;
        addr_sel = 0; c_sel = 0; operation = 2'b00; flags_reg_enable = 0;
    endtask

    task automatic model_write(input logic [1:0] r, input logic [DW-1:0] v);
`ifdef K_AND_S_R0_ZERO_EN
        if (r != 2'd0) m_reg[r] = v;
`else
        m_reg[r] = v;
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        m_pc = '0;
        m_z = 0; m_n = 0; m_u = 0; m_s = 0;
    endtask

    // Reference ALU built on integer arithmetic and range tests.
    task automatic model_alu(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             output logic [DW-1:0] res, output logic z, output logic n,
                             output logic u, output logic s);
        int wide;
        int sgn;
        u = 0;
        s = 0;
        case (op)
            2'b01: begin
                wide = int'(a) + int'(b);
                sgn  = int'($signed(a)) + int'($signed(b));
                res  = wide[15:0];
                u    = (wide > 65535);
                s    = (sgn > 32767) || (sgn < -32768);
            end
            2'b10: begin
                wide = int'(a) - int'(b);
                sgn  = int'($signed(a)) - int'($signed(b));
                res  = wide[15:0];
                u    = (a < b);
                s    = (sgn > 32767) || (sgn < -32768);
            end
            2'b11:   res = a & b;
            default: res = a | b;
        endcase
        z = (res == 16'h0000);
        n = res[15];
    endtask

    task automatic load_ir(input logic [DW-1:0] v);
        ram_data_in = v;
        ir_enable   = 1;
        tick();
        ir_enable   = 0;
    endtask

    task automatic write_load(input logic [1:0] r, input logic [DW-1:0] v);
        load_ir(16'h8103 | (16'(r) << 5));
        ram_data_in      = v;
        c_sel            = 0;
        write_reg_enable = 1;
        tick();
        write_reg_enable = 0;
        model_write(r, v);
    endtask

    task automatic alu_instr(input logic [7:0] opc, input logic [1:0] c, input logic [1:0] a,
                             input logic [1:0] b, input logic [1:0] op, input logic wr, input logic fl);
        logic [DW-1:0] av, bv, res;
        logic          z, n, u, s;
        load_ir({opc, 2'b00, b, a, c});
        av = m_reg[a];
        bv = (opc == 8'h91) ? m_reg[a] : m_reg[b];
        model_alu(op, av, bv, res, z, n, u, s);
        operation        = op;
        c_sel            = 1;
        write_reg_enable = wr;
        flags_reg_enable = fl;
        tick();
        write_reg_enable = 0;
        flags_reg_enable = 0;
        c_sel            = 0;
        if (wr) model_write(c, res);
        if (fl) begin
            m_z = z; m_n = n; m_u = u; m_s = s;
        end
    endtask

    task automatic observe_reg(input logic [1:0] r);
        load_ir(16'h8200 | (16'(r) << 5));
        #1;
        sb_push($sformatf("r%0d", r), 32'(m_reg[r]));
        sb_pop(32'(ram_data_out));
    endtask

    task automatic check_flags(input string tag);
        #1;
        sb_push({tag, "_zero"}, 32'(m_z));
        sb_push({tag, "_neg"},  32'(m_n));
        sb_push({tag, "_uov"},  32'(m_u));
        sb_push({tag, "_sov"},  32'(m_s));
        sb_pop(32'(zero_op));
        sb_pop(32'(neg_op));
        sb_pop(32'(unsigned_overflow));
        sb_pop(32'(signed_overflow));
    endtask

    task automatic check_pc(input string tag);
        addr_sel = 0;
        #1;
        sb_push(tag, 32'(m_pc));
        sb_pop(32'(ram_addr));
    endtask

    task automatic check_dec(input string tag, input decoded_instruction_type exp);
        #1;
        sb_push(tag, 32'(exp));
        sb_pop(32'(decoded_instruction));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0]              opc;
        decoded_instruction_type exp;
    } dec_vec_t;
    dec_vec_t dec_tbl[$];

    initial begin
        idle();
        rst_n       = 0;
        ram_data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_pc("reset_pc");
        check_dec("reset_dec", I_NOP);
        check_flags("reset");
        sb_push("reset_store_data", 32'h0);
        sb_pop(32'(ram_data_out));
        rst_n = 1;

        // Fetch: IR captures data at the old PC while PC advances.
        ram_data_in = 16'h8103;
        pc_enable   = 1;
        ir_enable   = 1;
        tick();
        pc_enable   = 0;
        ir_enable   = 0;
        m_pc        = m_pc + 1'b1;
        check_dec("fetch_dec", I_LOAD);
        check_pc("fetch_pc");
        addr_sel = 1;
        #1;
        sb_push("fetch_ir_addr", 32'h03);
        sb_pop(32'(ram_addr));
        addr_sel = 0;

        // LOAD then STORE
        write_load(2'd1, 16'h1234);
        load_ir(16'h8223);
        addr_sel = 1;
        #1;
        sb_push("store_data", 32'(m_reg[1]));
        sb_pop(32'(ram_data_out));
        sb_push("store_addr", 32'h03);
        sb_pop(32'(ram_addr));
        addr_sel = 0;

        // ADD with signed overflow
        write_load(2'd1, 16'h7FFF);
        write_load(2'd2, 16'h0001);
        alu_instr(8'hA1, 2'd2, 2'd1, 2'd2, 2'b01, 1, 1);
        check_flags("add_sov");
        observe_reg(2'd2);

        // SUB with borrow, then SUB to zero
        write_load(2'd1, 16'h0000);
        write_load(2'd2, 16'h0001);
        alu_instr(8'hA2, 2'd3, 2'd1, 2'd2, 2'b10, 1, 1);
        check_flags("sub_borrow");
        observe_reg(2'd3);
        write_load(2'd1, 16'h0001);
        alu_instr(8'hA2, 2'd3, 2'd1, 2'd2, 2'b10, 1, 1);
        check_flags("sub_zero");
        observe_reg(2'd3);

        // ADD with carry out, SUB with signed overflow, AND clears overflow flags
        write_load(2'd1, 16'hFFFF);
        write_load(2'd2, 16'h0002);
        alu_instr(8'hA1, 2'd3, 2'd1, 2'd2, 2'b01, 1, 1);
        check_flags("add_carry");
        observe_reg(2'd3);
        write_load(2'd1, 16'h8000);
        write_load(2'd2, 16'h0001);
        alu_instr(8'hA2, 2'd3, 2'd1, 2'd2, 2'b10, 1, 1);
        check_flags("sub_sov");
        write_load(2'd1, 16'hF0F0);
        write_load(2'd2, 16'h8F00);
        alu_instr(8'hA3, 2'd3, 2'd1, 2'd2, 2'b11, 1, 1);
        check_flags("and");
        observe_reg(2'd3);

        // Flags hold without enable; register holds without write enable
        alu_instr(8'hA4, 2'd3, 2'd1, 2'd2, 2'b00, 1, 0);
        check_flags("flags_hold");
        observe_reg(2'd3);
        alu_instr(8'hA1, 2'd3, 2'd1, 2'd1, 2'b01, 0, 1);
        check_flags("flags_no_write");
        observe_reg(2'd3);

        // Decode sweep including unassigned opcodes
        dec_tbl = '{'{8'h00, I_NOP}, '{8'h01, I_BRANCH}, '{8'h02, I_BZERO}, '{8'h03, I_BNEG},
                    '{8'h04, I_BOV}, '{8'h05, I_BNOV}, '{8'h0A, I_BNNEG}, '{8'h0B, I_BNZERO},
                    '{8'h81, I_LOAD}, '{8'h82, I_STORE}, '{8'h91, I_MOVE}, '{8'hA1, I_ADD},
                    '{8'hA2, I_SUB}, '{8'hA3, I_AND}, '{8'hA4, I_OR}, '{8'hFF, I_HALT},
                    '{8'h06, I_NOP}, '{8'h90, I_NOP}, '{8'hA5, I_NOP}};
        foreach (dec_tbl[i]) begin
            load_ir({dec_tbl[i].opc, 8'h00});
            check_dec($sformatf("dec_%02h", dec_tbl[i].opc), dec_tbl[i].exp);
        end

        // PC increment wrap, then branch
        for (int i = 0; i < 40 && m_pc != 5'd31; i++) begin
            pc_enable = 1;
            branch    = 0;
            tick();
            pc_enable = 0;
            m_pc      = m_pc + 1'b1;
        end
        check_pc("pc_max");
        pc_enable = 1;
        tick();
        pc_enable = 0;
        m_pc      = m_pc + 1'b1;
        check_pc("pc_wrap");
        load_ir(16'h0115);
        check_dec("branch_dec", I_BRANCH);
        pc_enable = 1;
        branch    = 1;
        tick();
        pc_enable = 0;
        branch    = 0;
        m_pc      = 5'h15;
        check_pc("pc_branch");

        // MOVE r0 <- r1 (B operand differs, so a wrong B would alter the copy)
        write_load(2'd1, 16'hABCD);
        write_load(2'd2, 16'h5432);
        alu_instr(8'h91, 2'd0, 2'd1, 2'd2, 2'b00, 1, 1);
        check_flags("move");
        observe_reg(2'd0);
        write_load(2'd0, 16'h1111);
        observe_reg(2'd0);

        // Reset asserted in the middle of a write/fetch cycle
        load_ir(16'h8123);
        ram_data_in      = 16'h5555;
        write_reg_enable = 1;
        pc_enable        = 1;
        ir_enable        = 1;
        flags_reg_enable = 1;
        @(negedge clk);
        rst_n = 0;
        model_reset();
        #1;
        check_flags("midrst");
        check_pc("midrst_pc");
        check_dec("midrst_dec", I_NOP);
        tick();
        idle();
        #1;
        rst_n = 1;
        for (int r = 0; r < 4; r++) observe_reg(2'(r));
        check_pc("post_rst_pc");
        check_flags("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
